// File: rtl/vcxo_pump_modulator.sv
// Charge-pump drive for the VCXO loop: re-times and clamps the asynchronous duty word,
// slews the applied level at a bounded rate and emits a first-order delta-sigma bitstream.
module vcxo_pump_modulator #(
  parameter int unsigned FULL_SCALE = 32000,
  parameter int unsigned INIT_LEVEL = 16000,
  parameter int unsigned SLEW_DIV   = 1024,
  parameter int unsigned SLEW_STEP  = 16,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        hold,
  input  logic [31:0] pwm_target,
  output logic        pump,
  output logic [15:0] level,
  output logic [15:0] target,
  output logic        settled
);

  localparam int unsigned LW = 16;
  localparam int unsigned AW = LW + 1;
  localparam int unsigned IW = 32;
  localparam int unsigned TW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int unsigned SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

  localparam logic [LW-1:0] FS_L      = LW'(FULL_SCALE);
  localparam logic [LW-1:0] INIT_L    = LW'(INIT_LEVEL);
  localparam logic [LW-1:0] STEP_L    = LW'(SLEW_STEP);
  localparam logic [AW-1:0] FS_A      = AW'(FULL_SCALE);
  localparam logic [IW-1:0] FS_I      = IW'(FULL_SCALE);
  localparam logic [TW-1:0] TICK_LAST = TW'(SLEW_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);

  logic [IW-1:0] s1_q, s2_q, s2_prev_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] target_q, target_d;
  logic [LW-1:0] acc_q, acc_d;
  logic          pump_q, pump_d;
  logic          settled_q, settled_d;

  logic [LW-1:0] clamp_c;
  logic          accept_c;
  logic          tick_c;
  logic [AW-1:0] up_c;
  logic [AW-1:0] sum_c;

  // Capture filter, slew limiter and delta-sigma modulator next-state logic.
  always_comb begin
    clamp_c   = s2_q[LW-1:0];
    stab_d    = stab_q;
    accept_c  = 1'b0;
    target_d  = target_q;
    tick_c    = (tick_q == TICK_LAST);
    tick_d    = tick_q + TW'(1);
    up_c      = {1'b0, level_q} + AW'(SLEW_STEP);
    level_d   = level_q;
    sum_c     = {1'b0, acc_q} + {1'b0, level_q};
    pump_d    = 1'b0;
    acc_d     = '0;
    settled_d = 1'b0;

    if (s2_q[IW-1]) begin
      clamp_c = '0;
    end else if (s2_q > FS_I) begin
      clamp_c = FS_L;
    end

    if (s2_q != s2_prev_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_LAST) begin
      stab_d = stab_q + SW'(1);
    end

    // The current sample must also match, so a single-cycle glitch after a quiet spell is rejected.
    accept_c = (stab_q == STAB_LAST) && (s2_q == s2_prev_q) && (clamp_c != target_q);
    if (accept_c) begin
      target_d = clamp_c;
    end

    if (tick_c) begin
      tick_d = '0;
    end

    if (tick_c && !hold) begin
      if (level_q < target_q) begin
        level_d = (up_c >= {1'b0, target_q}) ? target_q : up_c[LW-1:0];
      end else if (level_q > target_q) begin
        level_d = ((level_q - target_q) <= STEP_L) ? target_q : (level_q - STEP_L);
      end
    end

    settled_d = (level_d == target_d);

    if (enable) begin
      if (sum_c >= FS_A) begin
        pump_d = 1'b1;
        acc_d  = LW'(sum_c - FS_A);
      end else begin
        acc_d  = sum_c[LW-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s2_prev_q <= '0;
      stab_q    <= '0;
      tick_q    <= '0;
      level_q   <= INIT_L;
      target_q  <= INIT_L;
      acc_q     <= '0;
      pump_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      s1_q      <= pwm_target;
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;
      stab_q    <= stab_d;
      tick_q    <= tick_d;
      level_q   <= level_d;
      target_q  <= target_d;
      acc_q     <= acc_d;
      pump_q    <= pump_d;
      settled_q <= settled_d;
    end
  end

  assign pump    = pump_q;
  assign level   = level_q;
  assign target  = target_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_vcxo_pump_modulator.sv
// Scoreboard bench for vcxo_pump_modulator: a per-edge behavioural model queues expected
// outputs, a negedge monitor compares them; directed checks cover the named scenarios.
module tb_vcxo_pump_modulator;

  localparam int FS   = 1000;
  localparam int INIT = 500;
  localparam int DIV  = 16;
  localparam int STEP = 16;
  localparam int STAB = 4;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        hold;
  logic [31:0] pwm_target;
  logic        pump;
  logic [15:0] level;
  logic [15:0] target;
  logic        settled;

  vcxo_pump_modulator #(
    .FULL_SCALE(FS), .INIT_LEVEL(INIT), .SLEW_DIV(DIV), .SLEW_STEP(STEP), .STABLE_CNT(STAB)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .hold(hold),
    .pwm_target(pwm_target), .pump(pump), .level(level), .target(target), .settled(settled)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int pump;
    int level;
    int target;
    int settled;
  } exp_t;

  exp_t   sb_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  // Reference model state
  int     m_level, m_target, m_acc, m_tick;
  longint m_s1;
  longint m_s2h[$];

  function automatic int clampv(input longint v);
    if (v < 0) return 0;
    if (v > FS) return FS;
    return int'(v);
  endfunction

  task automatic model_reset();
    exp_t e;
    m_level = INIT; m_target = INIT; m_acc = 0; m_tick = 0; m_s1 = 0;
    m_s2h.delete();
    // samples from before reset never count toward stability
    for (int i = 0; i < STAB - 1; i++) m_s2h.push_back(longint'(64'sh100_0000_0000) + longint'(i));
    m_s2h.push_back(0);
    m_s2h.push_back(0);
    e.pump = 0; e.level = INIT; e.target = INIT; e.settled = 0;
    sb_q.push_back(e);
  endtask

  task automatic model_step();
    exp_t   e;
    bit     stable;
    int     d, nl, nt, s, p;
    longint newest;
    newest = m_s2h[m_s2h.size()-1];
    stable = 1'b1;
    for (int k = 1; k <= STAB; k++)
      if (m_s2h[m_s2h.size()-1-k] != newest) stable = 1'b0;
    nl = m_level;
    if (m_tick == DIV - 1 && !hold) begin
      d = m_target - m_level;
      if (d > STEP) d = STEP;
      if (d < -STEP) d = -STEP;
      nl = m_level + d;
    end
    nt = (stable && clampv(newest) != m_target) ? clampv(newest) : m_target;
    if (enable) begin
      s = m_acc + m_level;
      p = s / FS;
      m_acc = s % FS;
    end else begin
      p = 0;
      m_acc = 0;
    end
    m_level  = nl;
    m_target = nt;
    m_tick   = (m_tick + 1) % DIV;
    m_s2h.push_back(m_s1);
    while (m_s2h.size() > STAB + 2) void'(m_s2h.pop_front());
    m_s1 = longint'($signed(pwm_target));
    e.pump = p; e.level = nl; e.target = nt; e.settled = (nl == nt) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  always @(posedge clk_in) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Monitor: one comparison per clock against the oldest queued expectation.
  always @(negedge clk_in) begin
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: DUT output with no expectation at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      if (pump !== 1'(e.pump) || level !== 16'(e.level) || target !== 16'(e.target) ||
          settled !== 1'(e.settled)) begin
        n_fail++;
        $display("FAIL sb_cycle t=%0t: got pump=%b level=%0d target=%0d settled=%b, want pump=%0d level=%0d target=%0d settled=%0d",
                 $time, pump, level, target, settled, e.pump, e.level, e.target, e.settled);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  function automatic int get_out(input int sel);
    case (sel)
      0: return int'(level);
      1: return int'(target);
      default: return int'(settled);
    endcase
  endfunction

  // Bounded wait on an output; the final comparison reports a timeout as a failure.
  task automatic wait_out(input int sel, input int v, input int budget, input string name,
                          output int elapsed);
    elapsed = 0;
    while (get_out(sel) != v && elapsed < budget) begin
      @(negedge clk_in);
      elapsed++;
    end
    check(name, get_out(sel), v);
  endtask

  task automatic count_window(input int n, output int ones, output int run1, output int run0);
    int r1, r0;
    ones = 0; run1 = 0; run0 = 0; r1 = 0; r0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (pump === 1'b1) begin ones++; r1++; r0 = 0; end
      else begin r0++; r1 = 0; end
      if (r1 > run1) run1 = r1;
      if (r0 > run0) run0 = r0;
    end
  endtask

  task automatic do_reset(input int low_cycles);
    #2 reset_n = 1'b0;
    #1;
    check("rst_pump", int'(pump), 0);
    check("rst_level", int'(level), INIT);
    check("rst_target", int'(target), INIT);
    check("rst_settled", int'(settled), 0);
    cyc(low_cycles);
    #2 reset_n = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, r1, r0, el;
    reset_n = 1'b0; enable = 1'b1; hold = 1'b0; pwm_target = 32'(INIT);

    // 1: reset state, mid-scale duty
    @(negedge clk_in);
    check("init_level", int'(level), INIT);
    check("init_target", int'(target), INIT);
    check("init_pump", int'(pump), 0);
    check("init_settled", int'(settled), 0);
    #2 reset_n = 1'b1;
    cyc(10);
    check("t1_target", int'(target), INIT);
    check("t1_settled", int'(settled), 1);
    count_window(FS, ones, r1, r0);
    check("t1_ones", ones, INIT);
    check("t1_run1", r1, 1);
    check("t1_run0", r0, 1);

    // 2: clamping at both ends
    pwm_target = 32'(-5);
    wait_out(1, 0, 8, "t2_target_lo", el);
    wait_out(0, 0, 700, "t2_level_lo", el);
    count_window(200, ones, r1, r0);
    check("t2_ones_lo", ones, 0);
    pwm_target = 32'(40000);
    wait_out(1, FS, 8, "t2_target_hi", el);
    wait_out(0, FS, 1200, "t2_level_hi", el);
    count_window(200, ones, r1, r0);
    check("t2_ones_hi", ones, 200);

    // 3: bounded-rate slew ramp
    pwm_target = 32'(INIT);
    wait_out(0, INIT, 800, "t3_level_back", el);
    cyc(1);
    check("t3_settled_pre", int'(settled), 1);
    pwm_target = 32'(600);
    for (int k = 1; k <= 7; k++) begin
      wait_out(0, (INIT + STEP * k > 600) ? 600 : INIT + STEP * k, (k == 1) ? 30 : DIV + 2,
               "t3_ramp", el);
      if (k > 1) check("t3_tick_spacing", el, DIV);
    end
    check("t3_settled_post", int'(settled), 1);

    // 4: fast toggling never accepted, then a stable value is
    for (int i = 0; i < 2000; i++) begin
      pwm_target = ((i / 2) % 2 == 1) ? 32'(100) : 32'(200);
      cyc(1);
    end
    check("t4_target_toggle", int'(target), 600);
    pwm_target = 32'(200);
    cyc(7);
    check("t4_target_stable", int'(target), 200);

    // 5: hold freezes the slew
    pwm_target = 32'(INIT);
    wait_out(0, INIT, 800, "t5_level_start", el);
    pwm_target = 32'(600);
    wait_out(0, INIT + 2 * STEP, 60, "t5_level_two_steps", el);
    hold = 1'b1;
    cyc(5 * DIV);
    check("t5_level_held", int'(level), INIT + 2 * STEP);
    check("t5_target_held", int'(target), 600);
    hold = 1'b0;
    wait_out(0, 600, 150, "t5_level_resume", el);

    // 6: reset mid-slew and mid-bitstream, then an enable pulse
    pwm_target = 32'(0);
    cyc(100);
    pwm_target = 32'(INIT);
    do_reset(2);
    cyc(4);
    check("t6_settled", int'(settled), 1);
    enable = 1'b0;
    count_window(20, ones, r1, r0);
    check("t6_ones_disabled", ones, 0);
    enable = 1'b1;
    count_window(FS, ones, r1, r0);
    check("t6_ones_after", ones, INIT);

    // Randomized segments checked by the scoreboard
    for (int seg = 0; seg < 60; seg++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) pwm_target = 32'($urandom_range(0, FS));
      else if (r == 6) pwm_target = 32'(-int'($urandom_range(1, 5000)));
      else if (r == 7) pwm_target = 32'($urandom_range(FS + 1, 70000));
      else pwm_target = $urandom;
      hold   = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 4) != 0);
      if (seg == 30) do_reset(int'($urandom_range(1, 3)));
      cyc(int'($urandom_range(1, 120)));
    end
    hold = 1'b0; enable = 1'b1;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
